// File: rtl/mux_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : mux_rr_sched
//  Description : Round-robin scheduler for a shared 8:1 single-bit mux.
//                Generates a registered one-hot grant, a binary mux select
//                and a valid qualifier. A grant is held until the owner
//                releases it, its request drops or the hold timeout fires.
//                One dead cycle (GAP) separates consecutive owners so the
//                mux output never switches while valid is high.
//                Optional feature macro: MUX_RR_SCHED_LOCK_EN. When it is
//                defined, lock=1 freezes the hold counter and blocks the
//                timeout release.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_sched #(
    parameter int NUM_REQ  = 8,
    parameter int SEL_W    = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    input  logic               lock,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic               valid,
    output logic               timeout
);

    // Index width for requester numbers; counter is at least one bit wide so
    // that MAX_HOLD=0 (timeout disabled) still elaborates cleanly.
    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(MAX_HOLD - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_RST  = c_IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   w_grant_nxt;
    logic [SEL_W-1:0]     r_sel;
    logic [SEL_W-1:0]     w_sel_nxt;
    logic                 r_valid;
    logic                 w_valid_nxt;
    logic                 r_timeout;
    logic                 w_timeout_nxt;
    logic [c_IDX_W-1:0]   r_last;
    logic [c_IDX_W-1:0]   w_last_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;

    logic                 w_found;
    logic [c_IDX_W-1:0]   w_win;
    logic [c_IDX_W-1:0]   w_owner;
    logic                 w_rel_done;
    logic                 w_rel_drop;
    logic                 w_rel_to;
    logic                 w_release;
    logic                 w_lock_act;

`ifdef MUX_RR_SCHED_LOCK_EN
    assign w_lock_act = lock;
`else
    // lock is accepted on the port but has no effect in this build.
    logic w_lock_unused;
    assign w_lock_unused = lock;
    assign w_lock_act    = 1'b0;
`endif

    // The owner is the binary index currently driven on sel.
    assign w_owner    = r_sel[c_IDX_W-1:0];
    assign w_rel_done = done[w_owner];
    assign w_rel_drop = ~req[w_owner];
    assign w_rel_to   = (MAX_HOLD != 0) && (r_cnt == c_HOLD_LAST) && !w_lock_act;
    assign w_release  = w_rel_done | w_rel_drop | w_rel_to;

    // Cyclic search for the first request strictly after the last owner.
    always_comb begin : p_search
        int idx;
        w_found = 1'b0;
        w_win   = '0;
        idx     = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(r_last) + i) % NUM_REQ;
            if (!w_found && req[c_IDX_W'(idx)]) begin
                w_found = 1'b1;
                w_win   = c_IDX_W'(idx);
            end
        end
    end

    // Next-state and next-output decode for the IDLE/GRANT/GAP controller.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = '0;
        w_sel_nxt     = r_sel;
        w_valid_nxt   = 1'b0;
        w_timeout_nxt = 1'b0;
        w_last_nxt    = r_last;
        w_cnt_nxt     = r_cnt;
        case (r_state)
            S_IDLE, S_GAP: begin
                if (en && w_found) begin
                    w_state_nxt        = S_GRANT;
                    w_grant_nxt[w_win] = 1'b1;
                    w_sel_nxt          = SEL_W'(w_win);
                    w_valid_nxt        = 1'b1;
                    w_cnt_nxt          = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GRANT: begin
                w_grant_nxt = r_grant;
                w_valid_nxt = 1'b1;
                // Saturating hold counter; frozen while a lock is active.
                if (!w_lock_act && (r_cnt != '1)) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
                if (w_release) begin
                    w_state_nxt   = S_GAP;
                    w_grant_nxt   = '0;
                    w_valid_nxt   = 1'b0;
                    w_last_nxt    = w_owner;
                    // Pulse only when the timeout alone forced the release.
                    w_timeout_nxt = w_rel_to & ~w_rel_done & ~w_rel_drop;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register and registered outputs, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_sel     <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_last    <= c_LAST_RST;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_sel     <= w_sel_nxt;
            r_valid   <= w_valid_nxt;
            r_timeout <= w_timeout_nxt;
            r_last    <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign grant   = r_grant;
    assign sel     = r_sel;
    assign valid   = r_valid;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_rr_sched
//  Description : Self-checking bench for mux_rr_sched: table-driven vectors
//                plus directed sequences for round-robin order, timeout,
//                done/timeout coincidence, async reset and lock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       lock = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] done = 8'h00;
    logic [7:0] grant;
    logic [3:0] sel;
    logic       valid;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic [7:0] done;
        logic [7:0] eg;
        logic [3:0] es;
        logic       ev;
        logic       et;
    } vec_t;

    vec_t vt[12];

    mux_rr_sched #(
        .NUM_REQ  (8),
        .SEL_W    (4),
        .MAX_HOLD (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .done    (done),
        .lock    (lock),
        .grant   (grant),
        .sel     (sel),
        .valid   (valid),
        .timeout (timeout)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] eg, input logic [3:0] es,
                         input logic ev, input logic et);
        total++;
        if (grant !== eg || sel !== es || valid !== ev || timeout !== et) begin
            bad++;
            $display("FAIL %s: got grant=%h sel=%0d valid=%b timeout=%b, want grant=%h sel=%0d valid=%b timeout=%b",
                     name, grant, sel, valid, timeout, eg, es, ev, et);
        end
    endtask

    // Apply inputs for one cycle, then sample just after the rising edge.
    task automatic step(input logic e, input logic [7:0] r, input logic [7:0] d);
        en   = e;
        req  = r;
        done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'h00;
        done  = 8'h00;
        lock  = 1'b0;
        @(posedge clk);
        #1;
        check("reset", 8'h00, 4'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // en, req, done -> grant, sel, valid, timeout (pointer starts at 7)
        vt[0]  = '{1'b1, 8'h04, 8'h00, 8'h04, 4'd2, 1'b1, 1'b0};
        vt[1]  = '{1'b1, 8'h04, 8'h04, 8'h00, 4'd2, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 8'h00, 8'h00, 8'h00, 4'd2, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 8'h01, 8'h00, 8'h00, 4'd2, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 8'h01, 8'h00, 8'h01, 4'd0, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 8'h01, 8'h02, 8'h01, 4'd0, 1'b1, 1'b0};
        vt[6]  = '{1'b0, 8'h00, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 8'h10, 8'h10, 8'h10, 4'd4, 1'b1, 1'b0};
        vt[8]  = '{1'b1, 8'h18, 8'h00, 8'h10, 4'd4, 1'b1, 1'b0};
        vt[9]  = '{1'b1, 8'h08, 8'h00, 8'h00, 4'd4, 1'b0, 1'b0};
        vt[10] = '{1'b1, 8'h18, 8'h00, 8'h08, 4'd3, 1'b1, 1'b0};
        vt[11] = '{1'b1, 8'h00, 8'h00, 8'h00, 4'd3, 1'b0, 1'b0};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(vt[i].en, vt[i].req, vt[i].done);
            check($sformatf("vec%0d", i), vt[i].eg, vt[i].es, vt[i].ev, vt[i].et);
        end

        // Round-robin with all requesting: 3 grant cycles, 1 gap, order 0..7,0
        do_reset();
        for (int k = 0; k < 9; k++) begin
            logic [7:0] oh;
            logic [3:0] ow;
            ow = 4'(k % 8);
            oh = 8'h01 << ow;
            for (int c = 0; c < 3; c++) begin
                step(1'b1, 8'hFF, 8'h00);
                check($sformatf("rr_grant%0d_c%0d", k, c), oh, ow, 1'b1, 1'b0);
            end
            step(1'b1, 8'hFF, oh);
            check($sformatf("rr_gap%0d", k), 8'h00, ow, 1'b0, 1'b0);
        end

        // Timeout: sole requester held for 16 cycles, pulse, regrant
        do_reset();
        for (int c = 1; c <= 16; c++) begin
            step(1'b1, 8'h01, 8'h00);
            check($sformatf("to_hold%0d", c), 8'h01, 4'd0, 1'b1, 1'b0);
        end
        step(1'b1, 8'h01, 8'h00);
        check("to_pulse", 8'h00, 4'd0, 1'b0, 1'b1);
        step(1'b1, 8'h01, 8'h00);
        check("to_regrant", 8'h01, 4'd0, 1'b1, 1'b0);

        // done coincides with the last hold cycle; non-owner done ignored
        for (int c = 2; c <= 16; c++) begin
            step(1'b1, 8'h01, (c == 8) ? 8'h02 : 8'h00);
            check($sformatf("co_hold%0d", c), 8'h01, 4'd0, 1'b1, 1'b0);
        end
        step(1'b1, 8'h01, 8'h01);
        check("co_release", 8'h00, 4'd0, 1'b0, 1'b0);

        // Asynchronous reset mid-grant, pointer restarts at 0
        do_reset();
        step(1'b1, 8'h20, 8'h00);
        check("ar_grant5", 8'h20, 4'd5, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_async", 8'h00, 4'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 8'hA0, 8'h00);
        check("ar_first", 8'h20, 4'd5, 1'b1, 1'b0);

        // Lock held on owner 3
        do_reset();
        lock = 1'b1;
        step(1'b1, 8'h08, 8'h00);
        check("lk_grant", 8'h08, 4'd3, 1'b1, 1'b0);
`ifdef MUX_RR_SCHED_LOCK_EN
        for (int c = 2; c <= 40; c++) begin
            step(1'b1, 8'h08, 8'h00);
            check($sformatf("lk_hold%0d", c), 8'h08, 4'd3, 1'b1, 1'b0);
        end
        step(1'b1, 8'h08, 8'h08);
        check("lk_done", 8'h00, 4'd3, 1'b0, 1'b0);
`else
        for (int c = 2; c <= 16; c++) begin
            step(1'b1, 8'h08, 8'h00);
            check($sformatf("lk_hold%0d", c), 8'h08, 4'd3, 1'b1, 1'b0);
        end
        step(1'b1, 8'h08, 8'h00);
        check("lk_timeout", 8'h00, 4'd3, 1'b0, 1'b1);
`endif
        lock = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
